// File: rtl/img_mem_arbiter_if.sv
// img_mem_arbiter_if: video, host and RAM buses of the image memory arbiter.
interface img_mem_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_q;
    logic              vid_valid;
    logic              vid_miss;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, mem_q,
        output vid_q, vid_valid, vid_miss, host_gnt, host_rdata, host_rvalid,
               mem_addr, mem_wdata, mem_we
    );

    modport master (
        output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, mem_q,
        input  vid_q, vid_valid, vid_miss, host_gnt, host_rdata, host_rvalid,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter: single-port image RAM arbiter, video priority, 2-cycle tagged reads.
// Define ARB_STARVE_GUARD_EN to let a starved host pre-empt one video read.
module img_mem_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    img_mem_arbiter_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_VID = 2'd1, S_HRD = 2'd2, S_HWR = 2'd3;
    localparam logic [1:0] T_NONE = 2'd0, T_VID = 2'd1, T_HOST = 2'd2;

    logic [1:0]        r_state, r_tag0, r_tag1;
    logic [1:0]        w_next, w_tag;
    logic              w_host_ok, w_guard, w_vid, w_host;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, r_vid_q, r_host_rdata;
    logic              r_vid_valid, r_host_rvalid;

    // Host states share bit 1, so the grant pulse is just the state MSB.
    always_comb begin
        w_host_ok = bus.host_req && !r_state[1];
        w_vid     = bus.vid_req && !w_guard;
        w_host    = w_host_ok && !w_vid;
        w_next    = w_vid ? S_VID : w_host ? (bus.host_we ? S_HWR : S_HRD) : S_IDLE;
        w_tag     = (w_next == S_VID) ? T_VID : (w_next == S_HRD) ? T_HOST : T_NONE;
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_miss;
    logic             r_vid_miss;

    assign w_guard      = w_host_ok && bus.vid_req && (r_cnt == CNT_W'(STARVE_MAX));
    assign bus.vid_miss = r_vid_miss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_miss     <= '0;
            r_vid_miss <= 1'b0;
        end else begin
            r_cnt      <= (w_host || !bus.host_req) ? '0 :
                          (w_host_ok && w_vid && r_cnt != CNT_W'(STARVE_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;
            r_miss     <= {r_miss[0], w_guard};
            r_vid_miss <= r_miss[1];
        end
    end
`else
    // Video always wins; the comparison only keeps STARVE_MAX referenced.
    assign w_guard      = (STARVE_MAX < 0);
    assign bus.vid_miss = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_tag0        <= T_NONE;
            r_tag1        <= T_NONE;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_vid_q       <= '0;
            r_vid_valid   <= 1'b0;
            r_host_rdata  <= '0;
            r_host_rvalid <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_mem_addr    <= (w_next == S_VID) ? bus.vid_addr : w_next[1] ? bus.host_addr : r_mem_addr;
            r_mem_wdata   <= (w_next == S_HWR) ? bus.host_wdata : r_mem_wdata;
            r_tag0        <= w_tag;
            r_tag1        <= r_tag0;
            r_vid_valid   <= (r_tag1 == T_VID);
            r_vid_q       <= (r_tag1 == T_VID) ? bus.mem_q : r_vid_q;
            r_host_rvalid <= (r_tag1 == T_HOST);
            r_host_rdata  <= (r_tag1 == T_HOST) ? bus.mem_q : r_host_rdata;
        end
    end

    assign bus.host_gnt    = r_state[1];
    assign bus.mem_we      = (r_state == S_HWR);
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.vid_q       = r_vid_q;
    assign bus.vid_valid   = r_vid_valid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.host_rvalid = r_host_rvalid;
endmodule

// File: doc/img_mem_arbiter.md
# img_mem_arbiter

Single-port arbiter for the 400×400 8-bit grayscale image RAM. It shares the RAM between the VGA scan-out reader, which has hard real-time priority, and a host port used to load or process pixels. It issues one RAM access per cycle and returns tagged read data with a fixed latency.

## Interface
Parameters:
- ADDR_W, 18, RAM address width (covers 160000 pixels)
- DATA_W, 8, pixel width
- STARVE_MAX, 64, consecutive denied host cycles before the starvation guard fires (only used with guard compiled in)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request, sampled every cycle
- vid_addr  in  ADDR_W  video read address
- vid_q  out  DATA_W  video read data
- vid_valid  out  1  vid_q valid this cycle
- vid_miss  out  1  video read was dropped by the starvation guard (tied 0 without guard)
- host_req  in  1  host access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  one-cycle grant pulse
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid this cycle
- mem_addr  out  ADDR_W  RAM address, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_we  out  1  RAM write enable, registered
- mem_q  in  DATA_W  RAM read data, one cycle after mem_addr is latched by RAM

## Operation
- Grant state register: IDLE, VID, HOST_RD, HOST_WR. It is updated every edge from sampled requests.
- Priority rules:
  - vid_req=1 → VID.
  - Otherwise, host_req=1 and host_gnt=0 → HOST_RD or HOST_WR per host_we.
  - Otherwise → IDLE.
- The host is never granted in two consecutive cycles. host_req is ignored in any cycle where host_gnt=1. Host peak rate is therefore one access per 2 cycles.
- Host handshake:
  - host_req, host_we, host_addr and host_wdata stay stable from assertion until the cycle host_gnt=1.
  - The host may drop or change its request in the grant cycle.
- VID/HOST_RD: mem_addr ← requester address, mem_we ← 0.
- HOST_WR: mem_addr/mem_wdata ← host values, mem_we ← 1 for exactly one cycle. No rvalid is produced for writes.
- IDLE: mem_we ← 0; mem_addr holds its last value.
- A 2-stage tag pipeline (NONE/VID/HOST) carries each read. At the last stage, mem_q is registered into vid_q or host_rdata and the matching valid pulses. Any output data not being updated holds its value.
- Starvation counter: 0..STARVE_MAX, saturating.
  - Increments on each cycle host_req=1 is denied because of video.
  - Clears on host grant or when host_req=0.
- Reset (asynchronous, any time):
  - State → IDLE, tag pipeline → NONE, counter → 0.
  - All outputs → 0, including mem_addr, mem_we, vid_q, host_rdata and all valids.
  - In-flight reads are discarded; no valid pulses after reset release for requests issued before it.

## Timing
- A request sampled at edge E0 drives mem_addr/mem_we and host_gnt (for host) during cycle E0→E1.
- RAM latches the address at E1.
- vid_valid/host_rvalid and data are registered at E2, so read latency is exactly 2 cycles from the sampling edge.
- Back-to-back video reads (vid_req held high) give one vid_valid per cycle, in order, latency 2.
- Writes commit at E1 (RAM edge). A read to the same address sampled at E1 or later returns the new data.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - When the counter equals STARVE_MAX and both requests are present, the host wins that cycle.
  - The dropped video read produces vid_miss=1 (vid_valid=0, vid_q held) 2 cycles later.
  - The counter then clears.
- ARB_STARVE_GUARD_EN undefined:
  - Video always wins.
  - The counter is not built.
  - vid_miss is constant 0.
  - The host may starve indefinitely while vid_req stays high.

## Test plan
- Reset: drive all requests during reset, then release → every output 0; first vid_valid appears exactly 2 cycles after the first sampled vid_req.
- Video stream: vid_req=1 for 10 cycles, addresses 0..9, RAM preloaded with mem[a]=a+5 → 10 consecutive vid_valid pulses with vid_q=5..14 in order, starting cycle 2.
- Host write then read: host writes 0xA5 to address 159999, then reads it, with vid_req=0 → host_gnt for the write with mem_we=1 for one cycle; read grant exactly 2 cycles later (no consecutive host grants); host_rvalid with host_rdata=0xA5 2 cycles after the read grant.
- Contention: vid_req and host_req both held 5 cycles, then vid_req drops → no host_gnt during the 5 cycles; host_gnt the cycle after vid_req is sampled low.
- Guard (ARB_STARVE_GUARD_EN, STARVE_MAX=64): vid_req held, host_req asserted continuously → host_gnt on the 65th cycle of host_req; vid_miss=1 and vid_valid=0 2 cycles after that grant; without the macro, no host_gnt across 1000 cycles.
- Reset mid-read: assert rst_n=0 one cycle after a video read is issued → no vid_valid after release until new requests are sampled.
